multi_fifo_push_arbiter: RTL

Shares the wide push port of one `multi_fifo` between `REQUESTERS` producers, such as decode lanes or fetch/replay sources. Each cycle it selects at most one requester and forwards that requester's whole burst of up to `PUSH_WIDTH` elements, or nothing. Selection is round-robin, with a bounded opportunistic bypass so that a blocked wide burst cannot be starved.

---
 rtl/multi_fifo_push_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/multi_fifo_push_arbiter.sv
// multi_fifo_push_arbiter
// Shares the wide push port of one multi_fifo between REQUESTERS producers.
// Each cycle it grants at most one requester and forwards that requester's whole
// burst, or nothing. Selection is round-robin. A blocked wide burst may be
// bypassed by smaller bursts that fit, but only for MAX_WAIT consecutive cycles.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset (also gates all outputs)
//   req_data       in   REQUESTERS bursts of PUSH_WIDTH*DATA_WIDTH, requester 0 in LSBs
//   req_valid_ct   in   REQUESTERS counts of CT_WIDTH, 0 = idle
//   req_ready      out  one-hot (or zero) grant; the burst is accepted on this edge
//   fifo_din       out  granted burst, zero without a grant
//   fifo_valid_ct  out  granted count, zero without a grant
//   fifo_ready_ct  in   free slots reported by the fifo
//   grant_id       out  granted requester index, zero without a grant
module multi_fifo_push_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int PUSH_WIDTH = 4,
  parameter int REQUESTERS = 2,
  parameter int MAX_WAIT   = 2,
  localparam int CT_WIDTH  = $clog2(PUSH_WIDTH + 1),
  localparam int ID_WIDTH  = $clog2(REQUESTERS)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [REQUESTERS*PUSH_WIDTH*DATA_WIDTH-1:0] req_data,
  input  logic [REQUESTERS*CT_WIDTH-1:0]           req_valid_ct,
  output logic [REQUESTERS-1:0]                    req_ready,
  output logic [PUSH_WIDTH*DATA_WIDTH-1:0]         fifo_din,
  output logic [CT_WIDTH-1:0]                      fifo_valid_ct,
  input  logic [CT_WIDTH-1:0]                      fifo_ready_ct,
  output logic [ID_WIDTH-1:0]                      grant_id
);

  localparam int BURST_W  = PUSH_WIDTH * DATA_WIDTH;
  localparam int WT_WIDTH = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WT_WIDTH-1:0] WAIT_MAX  = WT_WIDTH'(MAX_WAIT);
  localparam logic [WT_WIDTH-1:0] WAIT_ONE  = WT_WIDTH'(1);
  localparam logic [WT_WIDTH-1:0] WAIT_ZERO = WT_WIDTH'(0);
  localparam logic [CT_WIDTH-1:0] CT_ZERO   = CT_WIDTH'(0);
  localparam logic [ID_WIDTH-1:0] ID_ZERO   = ID_WIDTH'(0);

  logic [ID_WIDTH-1:0] ptr_r;
  logic [ID_WIDTH-1:0] ptr_nxt_s;
  logic [WT_WIDTH-1:0] wait_ct_r;
  logic [WT_WIDTH-1:0] wait_ct_nxt_s;
  logic                cand_vld_s;
  logic [ID_WIDTH-1:0] cand_s;
  logic                cand_fits_s;
  logic                gnt_vld_s;
  logic [ID_WIDTH-1:0] gnt_s;

  // Index reached by stepping off positions forward from base, modulo REQUESTERS.
  // Both operands are below REQUESTERS, so a single wrap is enough.
  function automatic logic [ID_WIDTH-1:0] rr_idx(input logic [ID_WIDTH-1:0] base,
                                                 input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= REQUESTERS) begin
      sum = sum - REQUESTERS;
    end else begin
      sum = sum;
    end
    return ID_WIDTH'(sum);
  endfunction

  // Candidate: first requester at or after ptr with a nonzero count.
  always_comb begin
    cand_vld_s  = 1'b0;
    cand_s      = ID_ZERO;
    cand_fits_s = 1'b0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (!cand_vld_s &&
          (req_valid_ct[int'(rr_idx(ptr_r, k))*CT_WIDTH +: CT_WIDTH] != CT_ZERO)) begin
        cand_vld_s = 1'b1;
        cand_s     = rr_idx(ptr_r, k);
      end else begin
        cand_vld_s = cand_vld_s;
      end
    end
    if (cand_vld_s) begin
      cand_fits_s = (req_valid_ct[int'(cand_s)*CT_WIDTH +: CT_WIDTH] <= fifo_ready_ct);
    end else begin
      cand_fits_s = 1'b0;
    end
  end

  // Grant selection: the candidate if it fits, else a bounded bypass to the next
  // requester after the candidate whose burst fits.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_s     = ID_ZERO;
    if (!cand_vld_s) begin
      gnt_vld_s = 1'b0;
    end else if (cand_fits_s) begin
      gnt_vld_s = 1'b1;
      gnt_s     = cand_s;
    end else if (wait_ct_r < WAIT_MAX) begin
      for (int k = 1; k < REQUESTERS; k++) begin
        if (!gnt_vld_s &&
            (req_valid_ct[int'(rr_idx(cand_s, k))*CT_WIDTH +: CT_WIDTH] != CT_ZERO) &&
            (req_valid_ct[int'(rr_idx(cand_s, k))*CT_WIDTH +: CT_WIDTH] <= fifo_ready_ct)) begin
          gnt_vld_s = 1'b1;
          gnt_s     = rr_idx(cand_s, k);
        end else begin
          gnt_vld_s = gnt_vld_s;
        end
      end
    end else begin
      // Bypass budget exhausted: hold everyone until the candidate fits.
      gnt_vld_s = 1'b0;
    end
  end

  // Output drive; reset forces every output to zero regardless of inputs.
  always_comb begin
    req_ready     = {REQUESTERS{1'b0}};
    fifo_din      = {BURST_W{1'b0}};
    fifo_valid_ct = CT_ZERO;
    grant_id      = ID_ZERO;
    if (rst_n && gnt_vld_s) begin
      req_ready[gnt_s] = 1'b1;
      fifo_din         = req_data[int'(gnt_s)*BURST_W +: BURST_W];
      fifo_valid_ct    = req_valid_ct[int'(gnt_s)*CT_WIDTH +: CT_WIDTH];
      grant_id         = gnt_s;
    end else begin
      req_ready = {REQUESTERS{1'b0}};
    end
  end

  // Next pointer and bypass counter. A blocked candidate advances wait_ct even
  // when nothing could be bypassed; a changed candidate does not clear it.
  always_comb begin
    ptr_nxt_s     = ptr_r;
    wait_ct_nxt_s = wait_ct_r;
    if (!cand_vld_s) begin
      wait_ct_nxt_s = WAIT_ZERO;
    end else if (cand_fits_s) begin
      ptr_nxt_s     = rr_idx(cand_s, 1);
      wait_ct_nxt_s = WAIT_ZERO;
    end else if (wait_ct_r < WAIT_MAX) begin
      wait_ct_nxt_s = wait_ct_r + WAIT_ONE;
    end else begin
      wait_ct_nxt_s = wait_ct_r;
    end
  end

  // Arbitration state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= ID_ZERO;
      wait_ct_r <= WAIT_ZERO;
    end else begin
      ptr_r     <= ptr_nxt_s;
      wait_ct_r <= wait_ct_nxt_s;
    end
  end

endmodule
